// File: rtl/axi_module_pack.sv
// Width-up packer: gathers RATIO narrow valid/ready beats into one wide word, lowest lane first.
// A last_i beat closes the word early; keep_o marks the lanes that carry real beats.
module axi_module_pack #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned RATIO  = 4,
  localparam int unsigned CWIDTH = $clog2(RATIO)
) (
  input  logic                       aclk_i,
  input  logic                       areset_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DWIDTH-1:0]          data_i,
  input  logic                       last_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DWIDTH*RATIO-1:0]    data_o,
  output logic [RATIO-1:0]           keep_o,
  output logic                       last_o
);

  logic [CWIDTH-1:0]              cnt_q, cnt_d;
  logic [(RATIO-1)*DWIDTH-1:0]    acc_data_q, acc_data_d;
  logic [RATIO-2:0]               acc_keep_q, acc_keep_d;
  logic [DWIDTH*RATIO-1:0]        data_q, data_d;
  logic [RATIO-1:0]               keep_q, keep_d;
  logic                           last_q, last_d;
  logic                           valid_q, valid_d;

  logic                           accept;
  logic                           closing;
  logic [DWIDTH*RATIO-1:0]        word;
  logic [RATIO-1:0]               word_keep;

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;
  assign closing = accept & (last_i | (cnt_q == CWIDTH'(RATIO - 1)));

  // Candidate output word: filled accumulator lanes plus the current beat in lane cnt.
  always_comb begin
    word      = '0;
    word_keep = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      if (acc_keep_q[k]) begin
        word[k*DWIDTH +: DWIDTH] = acc_data_q[k*DWIDTH +: DWIDTH];
        word_keep[k]             = 1'b1;
      end
    end
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (cnt_q == CWIDTH'(k)) begin
        word[k*DWIDTH +: DWIDTH] = data_i;
        word_keep[k]             = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    data_d     = data_q;
    keep_d     = keep_q;
    last_d     = last_q;
    valid_d    = valid_q & ~ready_i;
    if (closing) begin
      data_d     = word;
      keep_d     = word_keep;
      last_d     = last_i;
      valid_d    = 1'b1;
      cnt_d      = '0;
      acc_keep_d = '0;
    end else if (accept) begin
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
        if (cnt_q == CWIDTH'(k)) begin
          acc_data_d[k*DWIDTH +: DWIDTH] = data_i;
          acc_keep_d[k]                  = 1'b1;
        end
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      cnt_q      <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule
